// File: rtl/uart_cmd_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl_if
// Purpose : bundles the byte-level UART handshake and the motor-drive register
//           outputs of uart_cmd_ctrl into a single interface.
// Signals :
//   rx_done   1-clk pulse, rx_data valid            (master -> slave)
//   rx_data   received byte                         (master -> slave)
//   rx_err    1-clk pulse, receiver framing error   (master -> slave)
//   tx_busy   transmitter busy                      (master -> slave)
//   tx_start  reply request, held until tx_busy     (slave -> master)
//   tx_data   reply byte, stable while tx_start     (slave -> master)
//   duty_a    PWM duty channel A                    (slave -> master)
//   duty_b    PWM duty channel B                    (slave -> master)
//   dir       motor direction                       (slave -> master)
//   motor_en  motor enable                          (slave -> master)
//   frame_ok  1-clk pulse, valid frame executed     (slave -> master)
//   frame_err 1-clk pulse, frame rejected/aborted   (slave -> master)
// The slave modport is the command controller; the master modport is the
// surrounding system (UART receiver/transmitter and PWM driver).
// ----------------------------------------------------------------------------
interface uart_cmd_ctrl_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] duty_a;
    logic [7:0] duty_b;
    logic       dir;
    logic       motor_en;
    logic       frame_ok;
    logic       frame_err;

    modport master (
        output rx_done, rx_data, rx_err, tx_busy,
        input  tx_start, tx_data, duty_a, duty_b, dir, motor_en, frame_ok, frame_err
    );

    modport slave (
        input  rx_done, rx_data, rx_err, tx_busy,
        output tx_start, tx_data, duty_a, duty_b, dir, motor_en, frame_ok, frame_err
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl
// Purpose : command sequencer between the UART and the motor-drive registers.
//           Parses fixed 6-byte frames (HDR0 HDR1 CMD D0 D1 CHK), validates the
//           8-bit additive checksum, executes the command on the duty /
//           direction / enable registers and queues a 1-byte ACK/NAK reply to
//           the UART transmitter.
// Ports   :
//   clk    system clock, single domain
//   reset  asynchronous assert, active-low
//   bus    uart_cmd_ctrl_if.slave (rx byte strobe, tx handshake, motor regs,
//          frame_ok/frame_err status pulses)
// Parameters:
//   TIMEOUT_CYC  max idle clocks between bytes inside a frame before abort
//   HDR0/HDR1    frame header bytes
// ----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA
) (
    input  logic           clk,
    input  logic           reset,
    uart_cmd_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CMD_DUTY = 8'h01;
    localparam logic [7:0] CMD_DIR  = 8'h02;
    localparam logic [7:0] CMD_PING = 8'h03;
    localparam logic [7:0] NAK      = 8'hEE;

    // States are named after the byte they are waiting for.
    typedef enum logic [3:0] {
        S_H0,
        S_H1,
        S_CMD,
        S_D0,
        S_D1,
        S_CHK,
        S_EXEC,
        S_TXW,
        S_TXH
    } state_e;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [7:0]       cmd_q,      cmd_d;
    logic [7:0]       d0_q,       d0_d;
    logic [7:0]       d1_q,       d1_d;
    logic [7:0]       chk_q,      chk_d;
    logic [7:0]       reply_q,    reply_d;
    logic [7:0]       duty_a_q,   duty_a_d;
    logic [7:0]       duty_b_q,   duty_b_d;
    logic             dir_q,      dir_d;
    logic             motor_en_q, motor_en_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;

    logic             in_frame;
    logic             abort;
    logic [7:0]       sum;
    logic             cmd_known;

    // Next-state and next-register logic.
    // A frame in progress (S_H1..S_CHK) is abandoned on rx_err, which takes
    // priority over a simultaneous rx_done, or when the inter-byte counter
    // reaches its last value without a byte arriving. Abort sends no reply.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        d0_d        = d0_q;
        d1_d        = d1_q;
        chk_d       = chk_q;
        reply_d     = reply_q;
        duty_a_d    = duty_a_q;
        duty_b_d    = duty_b_q;
        dir_d       = dir_q;
        motor_en_d  = motor_en_q;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        sum       = cmd_q + d0_q + d1_q;
        cmd_known = (cmd_q == CMD_DUTY) || (cmd_q == CMD_DIR) || (cmd_q == CMD_PING);
        in_frame  = (state_q == S_H1) || (state_q == S_CMD) || (state_q == S_D0) ||
                    (state_q == S_D1) || (state_q == S_CHK);
        abort     = in_frame && (bus.rx_err || (!bus.rx_done && (cnt_q == CNT_LAST)));

        if (in_frame) begin
            cnt_d = bus.rx_done ? '0 : cnt_q + CNT_W'(1);
        end

        if (abort) begin
            state_d     = S_H0;
            cnt_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            case (state_q)
                S_H0: begin
                    cnt_d = '0;
                    if (bus.rx_done && (bus.rx_data == HDR0)) begin
                        state_d = S_H1;
                    end
                end
                // A repeated HDR0 keeps us here so "HDR0 HDR0 HDR1" resyncs.
                S_H1: begin
                    if (bus.rx_done) begin
                        if (bus.rx_data == HDR1) begin
                            state_d = S_CMD;
                        end else if (bus.rx_data != HDR0) begin
                            state_d = S_H0;
                        end
                    end
                end
                S_CMD: begin
                    if (bus.rx_done) begin
                        cmd_d   = bus.rx_data;
                        state_d = S_D0;
                    end
                end
                S_D0: begin
                    if (bus.rx_done) begin
                        d0_d    = bus.rx_data;
                        state_d = S_D1;
                    end
                end
                S_D1: begin
                    if (bus.rx_done) begin
                        d1_d    = bus.rx_data;
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (bus.rx_done) begin
                        chk_d   = bus.rx_data;
                        state_d = S_EXEC;
                    end
                end
                // Registers only ever change here, one cycle after the CHK byte.
                S_EXEC: begin
                    state_d = S_TXW;
                    if ((sum == chk_q) && cmd_known) begin
                        frame_ok_d = 1'b1;
                        reply_d    = cmd_q | 8'h80;
                        if (cmd_q == CMD_DUTY) begin
                            duty_a_d = d0_q;
                            duty_b_d = d1_q;
                        end else if (cmd_q == CMD_DIR) begin
                            dir_d      = d0_q[0];
                            motor_en_d = d0_q[1];
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        reply_d     = NAK;
                    end
                end
                S_TXW: begin
                    if (!bus.tx_busy) begin
                        tx_data_d  = reply_q;
                        tx_start_d = 1'b1;
                        state_d    = S_TXH;
                    end
                end
                // tx_start is a level request; drop it once the transmitter
                // acknowledges by going busy.
                S_TXH: begin
                    if (bus.tx_busy) begin
                        tx_start_d = 1'b0;
                        state_d    = S_H0;
                    end
                end
                default: begin
                    state_d = S_H0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_H0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            d0_q        <= '0;
            d1_q        <= '0;
            chk_q       <= '0;
            reply_q     <= '0;
            duty_a_q    <= '0;
            duty_b_q    <= '0;
            dir_q       <= 1'b0;
            motor_en_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            chk_q       <= chk_d;
            reply_q     <= reply_d;
            duty_a_q    <= duty_a_d;
            duty_b_q    <= duty_b_d;
            dir_q       <= dir_d;
            motor_en_q  <= motor_en_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.duty_a    = duty_a_q;
    assign bus.duty_b    = duty_b_q;
    assign bus.dir       = dir_q;
    assign bus.motor_en  = motor_en_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;

endmodule
